// File: rtl/rob_pkg.sv
// Shared widths, index/count types and helpers for the reorder buffer.
package rob_pkg;

  localparam int PcLength     = 31;
  localparam int DataLength   = 31;
  localparam int RdLength     = 4;
  localparam int RobSize      = 16;
  localparam int RobIdxLength = 3;

  typedef logic [RobIdxLength:0]   idx_t;
  typedef logic [RobIdxLength+1:0] cnt_t;

  // Observation-only view of the buffer pointers.
  typedef struct packed {
    idx_t head;
    idx_t tail;
    cnt_t count;
  } rob_dbg_t;

  function automatic idx_t idx_inc(input idx_t i);
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/rob_if.sv
// Decoder / write-back / retire signal bundle around the reorder buffer.
interface rob_if;
  import rob_pkg::*;

  // Issue is valid when is_empty_from_decoder is low; the decoder must hold
  // off while is_full_to_decoder is high. Write-back buses present a
  // one-cycle is_finish_* strobe with no back-pressure. Retire outputs are
  // one-cycle pulses qualified by is_commit_to_rf.
  logic                is_empty_from_decoder;
  logic [PcLength:0]   pc_from_decoder;
  logic [RdLength:0]   rd_from_decoder;
  logic                is_finish_from_alu;
  logic [PcLength:0]   pc_from_alu;
  logic [DataLength:0] data_from_alu;
  logic                is_jump_from_alu;
  logic [PcLength:0]   target_pc_from_alu;
  logic                is_finish_from_slb;
  logic [PcLength:0]   pc_from_slb;
  logic [DataLength:0] data_from_slb;
  logic                is_full_to_decoder;
  logic                is_commit_to_rf;
  logic [RdLength:0]   rd_to_rf;
  logic [DataLength:0] data_to_rf;
  logic [PcLength:0]   pc_to_rf;
  logic                is_exception_to_rf;
  logic [PcLength:0]   pc_to_fetch;

  modport master (
    output is_empty_from_decoder, pc_from_decoder, rd_from_decoder,
           is_finish_from_alu, pc_from_alu, data_from_alu, is_jump_from_alu,
           target_pc_from_alu, is_finish_from_slb, pc_from_slb, data_from_slb,
    input  is_full_to_decoder, is_commit_to_rf, rd_to_rf, data_to_rf,
           pc_to_rf, is_exception_to_rf, pc_to_fetch
  );

  modport slave (
    input  is_empty_from_decoder, pc_from_decoder, rd_from_decoder,
           is_finish_from_alu, pc_from_alu, data_from_alu, is_jump_from_alu,
           target_pc_from_alu, is_finish_from_slb, pc_from_slb, data_from_slb,
    output is_full_to_decoder, is_commit_to_rf, rd_to_rf, data_to_rf,
           pc_to_rf, is_exception_to_rf, pc_to_fetch
  );

endinterface

// File: rtl/rob_match.sv
// Age-ordered tag search: first busy, not-yet-ready entry from head whose pc equals tag.
module rob_match
  import rob_pkg::*;
(
  input  logic [RobSize-1:0]             busy,
  input  logic [RobSize-1:0]             ready,
  input  logic [RobSize-1:0][PcLength:0] pc,
  input  idx_t                           head,
  input  logic [PcLength:0]              tag,
  output logic                           hit,
  output idx_t                           idx
);

  idx_t k;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    k   = '0;
    for (int i = 0; i < RobSize; i++) begin
      k = head + idx_t'(i);
      if (!hit && busy[k] && !ready[k] && (pc[k] == tag)) begin
        hit = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order write-back, in-order retire,
// with a full flush when a mispredicted jump reaches the head.
module rob
  import rob_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  rob_if.slave     bus,
  output rob_dbg_t dbg
);

  logic [RobSize-1:0]               busy_q;
  logic [RobSize-1:0]               ready_q;
  logic [RobSize-1:0]               jump_q;
  logic [RobSize-1:0][PcLength:0]   pc_q;
  logic [RobSize-1:0][PcLength:0]   target_q;
  logic [RobSize-1:0][DataLength:0] data_q;
  logic [RobSize-1:0][RdLength:0]   rd_q;
  idx_t                             head_q;
  idx_t                             tail_q;
  cnt_t                             count_q;

  logic                full_q;
  logic                commit_q;
  logic                exc_q;
  logic [RdLength:0]   rd_out_q;
  logic [DataLength:0] data_out_q;
  logic [PcLength:0]   pc_out_q;
  logic [PcLength:0]   fetch_q;

  logic               alu_hit, slb_hit, alu_wb, slb_wb;
  idx_t               alu_idx, slb_idx;
  logic [RobSize-1:0] slb_busy;
  logic               commit_go, flush_go, issue_go;
  cnt_t               count_nxt;

  rob_match u_alu_match (
    .busy (busy_q),
    .ready(ready_q),
    .pc   (pc_q),
    .head (head_q),
    .tag  (bus.pc_from_alu),
    .hit  (alu_hit),
    .idx  (alu_idx)
  );

  // Hiding the ALU's entry makes a same-tag SLB result land on the next-oldest match.
  always_comb begin
    slb_busy = busy_q;
    if (alu_wb) slb_busy[alu_idx] = 1'b0;
  end

  rob_match u_slb_match (
    .busy (slb_busy),
    .ready(ready_q),
    .pc   (pc_q),
    .head (head_q),
    .tag  (bus.pc_from_slb),
    .hit  (slb_hit),
    .idx  (slb_idx)
  );

  always_comb begin
    alu_wb    = bus.is_finish_from_alu && alu_hit;
    slb_wb    = bus.is_finish_from_slb && slb_hit;
    commit_go = busy_q[head_q] && ready_q[head_q];
    flush_go  = commit_go && jump_q[head_q];
    issue_go  = !bus.is_empty_from_decoder && (count_q < cnt_t'(RobSize));
    count_nxt = count_q;
    if (flush_go) count_nxt = '0;
    else          count_nxt = count_q + cnt_t'(issue_go) - cnt_t'(commit_go);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      ready_q    <= '0;
      jump_q     <= '0;
      pc_q       <= '0;
      target_q   <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      commit_q   <= 1'b0;
      exc_q      <= 1'b0;
      rd_out_q   <= '0;
      data_out_q <= '0;
      pc_out_q   <= '0;
      fetch_q    <= '0;
    end else if (rdy) begin
      commit_q <= commit_go;
      exc_q    <= flush_go;
      count_q  <= count_nxt;
      full_q   <= (count_nxt >= cnt_t'(RobSize - 2));
      if (commit_go) begin
        rd_out_q   <= rd_q[head_q];
        data_out_q <= data_q[head_q];
        pc_out_q   <= pc_q[head_q];
      end
      if (flush_go) begin
        // Same-cycle issue and write-back belong to the wrong path; drop them.
        fetch_q <= target_q[head_q];
        busy_q  <= '0;
        ready_q <= '0;
        jump_q  <= '0;
        head_q  <= '0;
        tail_q  <= '0;
      end else begin
        if (commit_go) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= idx_inc(head_q);
        end
        if (issue_go) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          jump_q[tail_q]  <= 1'b0;
          pc_q[tail_q]    <= bus.pc_from_decoder;
          rd_q[tail_q]    <= bus.rd_from_decoder;
          tail_q          <= idx_inc(tail_q);
        end
        if (alu_wb) begin
          ready_q[alu_idx]  <= 1'b1;
          data_q[alu_idx]   <= bus.data_from_alu;
          jump_q[alu_idx]   <= bus.is_jump_from_alu;
          target_q[alu_idx] <= bus.target_pc_from_alu;
        end
        if (slb_wb) begin
          ready_q[slb_idx] <= 1'b1;
          data_q[slb_idx]  <= bus.data_from_slb;
        end
      end
    end
  end

  assign bus.is_full_to_decoder = full_q;
  assign bus.is_commit_to_rf    = commit_q;
  assign bus.is_exception_to_rf = exc_q;
  assign bus.rd_to_rf           = rd_out_q;
  assign bus.data_to_rf         = data_out_q;
  assign bus.pc_to_rf           = pc_out_q;
  assign bus.pc_to_fetch        = fetch_q;

  assign dbg.head  = head_q;
  assign dbg.tail  = tail_q;
  assign dbg.count = count_q;

endmodule

// File: tb/tb_rob.sv
// Bench for rob: queue-based program-order model, scoreboard of expected retires,
// directed scenarios followed by randomized traffic.
module tb_rob;
  import rob_pkg::*;

  localparam int EW = 102;  // {exc, target, pc, data, rd}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;
  rob_dbg_t dbg;
  rob_if bus();

  rob u_dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus), .dbg(dbg));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          ready;
    bit          jump;
    logic [31:0] target;
  } mdl_t;

  mdl_t          mdl_q[$];
  logic [EW-1:0] exp_q[$];
  bit exp_commit = 1'b0, exp_exc = 1'b0, exp_full = 1'b0;
  bit act_edge = 1'b0, mon_en = 1'b0;
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.is_empty_from_decoder = 1'b1;
    bus.pc_from_decoder       = '0;
    bus.rd_from_decoder       = '0;
    bus.is_finish_from_alu    = 1'b0;
    bus.pc_from_alu           = '0;
    bus.data_from_alu         = '0;
    bus.is_jump_from_alu      = 1'b0;
    bus.target_pc_from_alu    = '0;
    bus.is_finish_from_slb    = 1'b0;
    bus.pc_from_slb           = '0;
    bus.data_from_slb         = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic set_issue(input logic [31:0] pc, input logic [4:0] rd);
    bus.is_empty_from_decoder = 1'b0;
    bus.pc_from_decoder       = pc;
    bus.rd_from_decoder       = rd;
  endtask

  task automatic set_alu(input logic [31:0] pc, input logic [31:0] data,
                         input bit jump, input logic [31:0] target);
    bus.is_finish_from_alu = 1'b1;
    bus.pc_from_alu        = pc;
    bus.data_from_alu      = data;
    bus.is_jump_from_alu   = jump;
    bus.target_pc_from_alu = target;
  endtask

  task automatic set_slb(input logic [31:0] pc, input logic [31:0] data);
    bus.is_finish_from_slb = 1'b1;
    bus.pc_from_slb        = pc;
    bus.data_from_slb      = data;
  endtask

  task automatic pick_open(output bit found, output logic [31:0] pc);
    int idxs[$];
    found = 1'b0;
    pc    = '0;
    for (int i = 0; i < mdl_q.size(); i++)
      if (!mdl_q[i].ready) idxs.push_back(i);
    if (idxs.size() > 0) begin
      found = 1'b1;
      pc    = mdl_q[idxs[$urandom_range(0, idxs.size() - 1)]].pc;
    end
  endtask

  task automatic drain();
    int budget = 300;
    bit found;
    logic [31:0] pc;
    while (mdl_q.size() > 0 && budget > 0) begin
      pick_open(found, pc);
      if (found) begin
        if ($urandom_range(0, 1) == 1) set_alu(pc, $urandom, 1'b0, 32'h0);
        else                           set_slb(pc, $urandom);
      end
      tick();
      budget--;
    end
    check("drain_done", 32'(mdl_q.size()), 32'd0);
    tick();
    tick();
  endtask

  // ---------------- reference model ----------------
  task automatic mdl_wb(input logic [31:0] tag, input logic [31:0] data, input bit is_alu,
                        input bit jump, input logic [31:0] target);
    bit   done = 1'b0;
    mdl_t e;
    for (int i = 0; i < mdl_q.size(); i++) begin
      if (!done && !mdl_q[i].ready && mdl_q[i].pc == tag) begin
        e       = mdl_q[i];
        e.ready = 1'b1;
        e.data  = data;
        if (is_alu) begin
          e.jump   = jump;
          e.target = target;
        end
        mdl_q[i] = e;
        done     = 1'b1;
      end
    end
  endtask

  initial begin
    int   n_before;
    bit   flushed;
    mdl_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        mdl_q.delete();
        exp_commit = 1'b0;
        exp_exc    = 1'b0;
        exp_full   = 1'b0;
        act_edge   = 1'b0;
      end else if (!rdy) begin
        act_edge = 1'b0;
      end else begin
        act_edge   = 1'b1;
        n_before   = mdl_q.size();
        flushed    = 1'b0;
        exp_commit = 1'b0;
        exp_exc    = 1'b0;
        if (n_before > 0 && mdl_q[0].ready) begin
          e = mdl_q[0];
          exp_q.push_back({e.jump, e.target, e.pc, e.data, e.rd});
          exp_commit = 1'b1;
          exp_exc    = e.jump;
          if (e.jump) begin
            mdl_q.delete();
            flushed = 1'b1;
          end else begin
            void'(mdl_q.pop_front());
          end
        end
        if (!flushed) begin
          if (bus.is_finish_from_alu)
            mdl_wb(bus.pc_from_alu, bus.data_from_alu, 1'b1, bus.is_jump_from_alu,
                   bus.target_pc_from_alu);
          if (bus.is_finish_from_slb)
            mdl_wb(bus.pc_from_slb, bus.data_from_slb, 1'b0, 1'b0, 32'h0);
          if (!bus.is_empty_from_decoder && n_before < RobSize) begin
            e = '{pc: bus.pc_from_decoder, rd: bus.rd_from_decoder, data: 32'h0,
                  ready: 1'b0, jump: 1'b0, target: 32'h0};
            mdl_q.push_back(e);
          end
        end
        exp_full = (mdl_q.size() >= RobSize - 2);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    logic          e_exc;
    logic [31:0]   e_tgt, e_pc, e_data;
    logic [4:0]    e_rd;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("commit_pulse", 32'(bus.is_commit_to_rf), 32'(exp_commit));
        check("exception_pulse", 32'(bus.is_exception_to_rf), 32'(exp_exc));
        check("full_flag", 32'(bus.is_full_to_decoder), 32'(exp_full));
        check("count", 32'(dbg.count), 32'(mdl_q.size()));
        if (act_edge && bus.is_commit_to_rf) begin
          if (exp_q.size() == 0) begin
            check("unexpected_commit_pc", bus.pc_to_rf, 32'h0);
          end else begin
            e = exp_q.pop_front();
            {e_exc, e_tgt, e_pc, e_data, e_rd} = e;
            check("retire_pc", bus.pc_to_rf, e_pc);
            check("retire_rd", 32'(bus.rd_to_rf), 32'(e_rd));
            check("retire_data", bus.data_to_rf, e_data);
            if (e_exc) check("fetch_target", bus.pc_to_fetch, e_tgt);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          found;
    logic [31:0] pc_a, pc_s;
    idle();
    rst = 1'b1;
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_commit", 32'(bus.is_commit_to_rf), 32'd0);
    check("rst_exception", 32'(bus.is_exception_to_rf), 32'd0);
    check("rst_full", 32'(bus.is_full_to_decoder), 32'd0);
    check("rst_rd", 32'(bus.rd_to_rf), 32'd0);
    check("rst_data", bus.data_to_rf, 32'd0);
    check("rst_pc", bus.pc_to_rf, 32'd0);
    check("rst_fetch", bus.pc_to_fetch, 32'd0);
    check("rst_count", 32'(dbg.count), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // single instruction, two cycles from write-back to retire
    set_issue(32'h100, 5'd5); tick();
    set_alu(32'h100, 32'd7, 1'b0, 32'h0); tick();
    check("t1_not_yet", 32'(bus.is_commit_to_rf), 32'd0);
    tick();
    check("t1_commit", 32'(bus.is_commit_to_rf), 32'd1);
    check("t1_rd", 32'(bus.rd_to_rf), 32'd5);
    check("t1_data", bus.data_to_rf, 32'd7);
    check("t1_pc", bus.pc_to_rf, 32'h100);
    tick();
    check("t1_pulse_drop", 32'(bus.is_commit_to_rf), 32'd0);

    // out-of-order finish, in-order retire
    set_issue(32'h100, 5'd1); tick();
    set_issue(32'h104, 5'd2); tick();
    set_issue(32'h108, 5'd3); tick();
    set_alu(32'h108, 32'h88, 1'b0, 32'h0); tick();
    set_slb(32'h100, 32'h11); tick();
    set_alu(32'h104, 32'h44, 1'b0, 32'h0); tick();
    check("t2_first", bus.pc_to_rf, 32'h100);
    tick();
    check("t2_second", bus.pc_to_rf, 32'h104);
    tick();
    check("t2_third", bus.pc_to_rf, 32'h108);
    check("t2_third_data", bus.data_to_rf, 32'h88);
    tick();

    // fill to capacity, then one dropped issue
    for (int i = 0; i < RobSize; i++) begin
      set_issue(32'h1000 + 32'(i) * 4, 5'(i));
      tick();
      if (i == RobSize - 4) check("t3_not_full", 32'(bus.is_full_to_decoder), 32'd0);
      if (i == RobSize - 3) check("t3_full", 32'(bus.is_full_to_decoder), 32'd1);
    end
    set_issue(32'h2000, 5'd1); tick();
    check("t3_dropped_count", 32'(dbg.count), 32'd16);
    drain();

    // mispredict flush
    set_issue(32'h200, 5'd1); tick();
    set_issue(32'h204, 5'd2); tick();
    set_issue(32'h208, 5'd3); tick();
    set_alu(32'h200, 32'h55, 1'b1, 32'h300); tick();
    tick();
    check("t4_exception", 32'(bus.is_exception_to_rf), 32'd1);
    check("t4_fetch", bus.pc_to_fetch, 32'h300);
    check("t4_count", 32'(dbg.count), 32'd0);
    set_alu(32'h204, 32'd9, 1'b0, 32'h0); tick();
    check("t4_stale_ignored", 32'(dbg.count), 32'd0);
    tick();
    check("t4_no_commit", 32'(bus.is_commit_to_rf), 32'd0);

    // duplicate tags: one finish readies only the older
    set_issue(32'h40, 5'd1); tick();
    set_issue(32'h40, 5'd2); tick();
    set_alu(32'h40, 32'hAA, 1'b0, 32'h0); tick();
    tick();
    check("t5_older_rd", 32'(bus.rd_to_rf), 32'd1);
    check("t5_older_data", bus.data_to_rf, 32'hAA);
    tick();
    check("t5_younger_waits", 32'(bus.is_commit_to_rf), 32'd0);
    set_slb(32'h40, 32'hBB); tick();
    tick();
    check("t5_younger_rd", 32'(bus.rd_to_rf), 32'd2);
    tick();

    // same tag on both ports in one cycle: ALU older, SLB next
    set_issue(32'h44, 5'd3); tick();
    set_issue(32'h44, 5'd4); tick();
    set_alu(32'h44, 32'h1, 1'b0, 32'h0);
    set_slb(32'h44, 32'h2); tick();
    tick();
    check("t5b_alu_older", bus.data_to_rf, 32'h1);
    tick();
    check("t5b_slb_next", bus.data_to_rf, 32'h2);
    tick();

    // rdy low freezes a pending commit, and holds a pulse
    set_issue(32'h500, 5'd7); tick();
    set_alu(32'h500, 32'h77, 1'b0, 32'h0); tick();
    rdy = 1'b0;
    repeat (3) begin
      tick();
      check("t6_frozen", 32'(bus.is_commit_to_rf), 32'd0);
    end
    rdy = 1'b1; tick();
    check("t6_commit", bus.pc_to_rf, 32'h500);
    rdy = 1'b0; tick();
    check("t6_pulse_held", 32'(bus.is_commit_to_rf), 32'd1);
    rdy = 1'b1; tick();
    check("t6_pulse_drop", 32'(bus.is_commit_to_rf), 32'd0);

    // randomized traffic with one mid-run reset
    for (int c = 0; c < 1500; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      rst = (c == 700);
      if ($urandom_range(0, 1) == 1 &&
          (!bus.is_full_to_decoder || $urandom_range(0, 7) == 0))
        set_issue(32'($urandom_range(1, 20)) << 2, 5'($urandom_range(0, 31)));
      pick_open(found, pc_a);
      if (found && $urandom_range(0, 1) == 1)
        set_alu(pc_a, $urandom, ($urandom_range(0, 15) == 0),
                32'($urandom_range(1, 1000)) << 2);
      else if ($urandom_range(0, 7) == 0)
        set_alu(32'hFFC, $urandom, 1'b0, 32'h0);
      pick_open(found, pc_s);
      if (found && $urandom_range(0, 2) == 0) begin
        if (bus.is_finish_from_alu && $urandom_range(0, 3) == 0) pc_s = bus.pc_from_alu;
        set_slb(pc_s, $urandom);
      end
      tick();
    end
    rst = 1'b0;
    rdy = 1'b1;
    drain();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob.md
# rob

Reorder buffer for the out-of-order RISC-V core. Allocates an entry for every instruction the decoder issues, collects results from the ALU and store/load buffer write-back buses, and retires entries strictly in program order to the register file (`is_commit`, `rd`, `data`, `pc`). A mispredicted jump retires with `is_exception` asserted, which flushes the register file's rename tags and restarts fetch. Entries are tagged by instruction PC, matching the register file's `RegQueue` tag scheme; tag 0 means "no producer".

## Interface
- `RobSize`, 16: number of entries, power of two.
- `RobIdxLength`, 3: index MSB, `log2(RobSize)-1`.
- `RdLength`, 4: destination-register MSB.

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `rdy`  in  1  global enable; low = hold all state and outputs
- `is_empty_from_decoder`  in  1  low = valid issue this cycle
- `pc_from_decoder`  in  32  issue PC/tag, never 0
- `rd_from_decoder`  in  5  destination register
- `is_finish_from_alu`  in  1  ALU result valid
- `pc_from_alu`, `data_from_alu`  in  32 each  ALU tag, result
- `is_jump_from_alu`  in  1  with finish: branch mispredicted
- `target_pc_from_alu`  in  32  correct next PC when mispredicted
- `is_finish_from_slb`  in  1  load/store result valid
- `pc_from_slb`, `data_from_slb`  in  32 each  SLB tag, result
- `is_full_to_decoder`  out  1  decoder must not issue
- `is_commit_to_rf`  out  1  retire pulse
- `rd_to_rf`  out  5; `data_to_rf`, `pc_to_rf`  out  32 each  retiring entry
- `is_exception_to_rf`  out  1  flush pulse, coincident with its commit
- `pc_to_fetch`  out  32  redirect target, valid with exception

## Operation
- Circular buffer: `head` (oldest), `tail` (next free), `count` (0..RobSize). Per entry: busy, ready, pc, rd, data, jump, target.
- Issue: `rdy` high, `is_empty_from_decoder` low, `count < RobSize` → write entry at `tail` (busy=1, ready=0), `tail+1` mod RobSize. Issue while `count == RobSize` is dropped.
- `is_full_to_decoder` registered, high when `count >= RobSize-2` after the cycle's updates; the slack covers the decoder's one-cycle registered issue.
- Write-back, per port: search busy, not-ready entries from `head` in age order. The first with `pc == pc_from_x` gets ready=1, data, and (ALU only) jump/target. No match → ignore. Both ports may hit different entries in one cycle. If both carry the same tag, ALU takes the oldest match and SLB the next.
- Commit: if `head` entry is busy and ready (registered state), drive outputs with its rd/data/pc, clear busy, `head+1`, `count-1`. One retire per cycle max.
- Mispredict: head entry with jump=1 commits with `is_exception_to_rf`=1 and `pc_to_fetch`=target. Next cycle all entries are invalid, `head=tail=count=0`. Issue and write-back in the flush cycle are discarded.
- Issue and commit in the same cycle: count unchanged.
- `rd == 0` entries still commit; the register file ignores the write.

## Timing
- Reset: all outputs 0, `head=tail=count=0`, all busy/ready cleared; `is_full_to_decoder`=0.
- Issue at cycle N → entry busy at N+1.
- Write-back at N → ready at N+1 → commit outputs at N+2, held one cycle. Minimum issue-to-retire latency is 2 cycles after write-back.
- Commit and exception outputs are single-cycle pulses and return to 0 when nothing retires.
- `rdy` low: no state change; outputs hold their last values, including pulses. The register file ignores them while `rdy` is low.
- `rst` mid-operation overrides everything in that cycle.

## Structure
- `parameters.v` (shared): existing `PcLength`, `DataLength`, `True`/`False`, `Zero`; add `RobSize`, `RobIdxLength`.
- One sub-module, `rob_match`: combinational age-ordered priority search. Inputs are the busy/ready/pc vectors, head, and a tag; outputs are hit and index. Instantiated once per write-back port.

## Test plan
- Reset then idle: all outputs 0; issue pc 0x100/rd 5, ALU finish pc 0x100 data 7 → commit pulse 2 cycles later with rd 5, data 7, pc 0x100.
- Out-of-order finish: issue 0x100, 0x104, 0x108; finish order 0x108, 0x100, 0x104 → commits in order 0x100, 0x104, 0x108 on consecutive cycles.
- Full: issue 16 without finishing → `is_full_to_decoder` high after the 14th; a 17th issue is dropped and count stays 16.
- Mispredict: issue 0x200 (jump), 0x204, 0x208; ALU finish 0x200 with jump and target 0x300 → commit of 0x200 with exception and `pc_to_fetch`=0x300; next cycle count 0. A later finish of 0x204 is ignored.
- Duplicate tag: two in-flight entries with pc 0x40; one finish 0x40 → only the older becomes ready and commits.
- `rdy` low for 3 cycles during pending commit → no state change; commit appears after `rdy` returns.
